// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core load/store port.
// Accepts one request per valid/ready handshake, waits WAIT_CYCLES, then
// commits the access to a word-organised RAM and pulses a response.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request (req_ready high once out of reset)
// WAIT   | request latched, counting down wait states
// RESP   | access committed on the entry edge; response pulses next cycle
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        commit;

  // Request seen by the commit logic: with zero wait states the access
  // commits on the handshake edge itself, before the latch has captured it.
  logic        c_we;
  logic [1:0]  c_size;
  logic        c_uns;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic          c_err;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_val;
  logic [3:0]    be;
  logic [31:0]   wr_al;

  logic [31:0] mem [DEPTH_WORDS];

  // Next-state, wait counter, request latch and commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select live inputs or latched request, then decode error and lanes.
  always_comb begin
    if (state_q == S_IDLE) begin
      c_we    = req_we;
      c_size  = req_size;
      c_uns   = req_unsigned;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_we    = we_q;
      c_size  = size_q;
      c_uns   = uns_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end

    c_err = (c_size == 2'b11) ||
            (c_size == 2'b01 && c_addr[0]) ||
            (c_size == 2'b10 && c_addr[1:0] != 2'b00) ||
            (c_addr[31:2] >= 30'(DEPTH_WORDS));

    widx    = c_addr[AW+1:2];
    rd_word = mem[widx];

    ld_val = rd_word;
    be     = 4'b1111;
    wr_al  = c_wdata;
    case (c_size)
      2'b00: begin
        ld_val = {24'd0, rd_word[8*c_addr[1:0] +: 8]};
        if (!c_uns) ld_val[31:8] = {24{ld_val[7]}};
        be     = 4'b0001 << c_addr[1:0];
        wr_al  = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        ld_val = {16'd0, (c_addr[1] ? rd_word[31:16] : rd_word[15:0])};
        if (!c_uns) ld_val[31:16] = {16{ld_val[15]}};
        be     = c_addr[1] ? 4'b1100 : 4'b0011;
        wr_al  = {2{c_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Response registers: data/err captured on RESP entry, valid one cycle after RESP.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_q == S_RESP);
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_err || c_we) ? 32'd0 : ld_val;
    end
  end

  // Control and response state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wr_al[8*i +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 4 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst          [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic int wc(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string nm, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready[d];
    if (!ok) chk({nm, " ready_timeout"}, 32'(req_ready[d]), 32'd1);
  endtask

  task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
  endtask

  task automatic idle_inputs(input int d);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b1;
    req_size[d]  = 2'b10;
    req_addr[d]  = 32'h0000_0044;
    req_wdata[d] = 32'hFFFF_FFFF;
  endtask

  // One full transaction with cycle-exact checks on ready and the response pulse.
  task automatic do_txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm);
    bit ok;
    int w = wc(d);
    wait_ready(d, nm, ok);
    if (!ok) return;
    drive(d, we, sz, uns, addr, wd);
    @(posedge clk);
    #1 idle_inputs(d);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      chk({nm, " busy_ready"}, 32'(req_ready[d]), 32'd0);
      chk({nm, " early_valid"}, 32'(rsp_valid[d]), 32'd0);
    end
    @(negedge clk);
    chk({nm, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
    chk({nm, " ready_back"}, 32'(req_ready[d]), 32'd1);
    chk({nm, " rdata"}, rsp_rdata[d], exp_rd);
    chk({nm, " err"}, 32'(rsp_err[d]), 32'(exp_err));
    @(negedge clk);
    chk({nm, " pulse_width"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      req_unsigned[d] = 1'b0;
      idle_inputs(d);
    end

    // Reset held for three cycles, then released away from the clock edge.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("rst_ready", 32'(req_ready[d]), 32'd0);
        chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      end
    end
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_err", 32'(rsp_err[0]), 32'd0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    #1 chk("rel_ready_low", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("rel_ready_high", 32'(req_ready[d]), 32'd1);
    chk("rel_valid", 32'(rsp_valid[0]), 32'd0);

    // Single-transaction vectors on the one-wait-state instance.
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_w10"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld_w10"});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0, 1'b0, "st_w20"});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0022, 32'hABCD_EF80, 32'h0, 1'b0, "st_b22"});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'h1234_F00D, 32'h0, 1'b0, "st_h20"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h0080_F00D, 1'b0, "ld_w20"});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_FF80, 1'b0, "ld_bs22"});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_0080, 1'b0, "ld_bu22"});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_F00D, 1'b0, "ld_hs20"});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_0080, 1'b0, "ld_hs22"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h0, 1'b1, "err_w06"});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'hAAAA_AAAA, 32'h0, 1'b1, "err_h21"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h0080_F00D, 1'b0, "ld_w20_kept"});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0, 1'b1, "err_sz11"});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'h5555_5555, 32'h0, 1'b1, "err_st_sz11"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         32'h0, 1'b1, "err_oob"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0,         32'h0, 1'b1, "err_hi_addr"});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, "st_last"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0, "ld_last"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h0080_F00D, 1'b0, "ld_w20_sz11"});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_005A, 32'h0, 1'b0, "st_b13"});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h5AAD_BEEF, 1'b0, "ld_w10_b"});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'hFFFF_FFBE, 1'b0, "ld_bs11"});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_5AAD, 1'b0, "ld_hu12"});

    foreach (vecs[i])
      do_txn(0, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
             vecs[i].exp_rd, vecs[i].exp_err, vecs[i].nm);

    // Zero wait states, req_valid held high across three stores.
    wait_ready(1, "b2b", ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: drive(1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1111_1111);
          1: drive(1, 1'b1, 2'b00, 1'b0, 32'h0000_0104, 32'h0000_0022);
          default: drive(1, 1'b1, 2'b01, 1'b0, 32'h0000_010A, 32'h0000_3333);
        endcase
        chk("b2b ready_even", 32'(req_ready[1]), 32'd1);
        chk("b2b valid_even", 32'(rsp_valid[1]), (i > 0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("b2b ready_odd", 32'(req_ready[1]), 32'd0);
        chk("b2b valid_odd", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
      end
      idle_inputs(1);
      chk("b2b last_valid", 32'(rsp_valid[1]), 32'd1);
      chk("b2b last_ready", 32'(req_ready[1]), 32'd1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("b2b no_dup", 32'(rsp_valid[1]), 32'd0);
      end
    end
    do_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_1111, 1'b0, "b2b ld100");
    do_txn(1, 1'b0, 2'b00, 1'b1, 32'h0000_0104, 32'h0, 32'h0000_0022, 1'b0, "b2b ld104");
    do_txn(1, 1'b0, 2'b01, 1'b1, 32'h0000_010A, 32'h0, 32'h0000_3333, 1'b0, "b2b ld10a");

    // Four wait states: reset during WAIT drops the store.
    do_txn(2, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1111_2222, 32'h0, 1'b0, "mid st_prior");
    do_txn(2, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1'b0, "mid ld_prior");
    wait_ready(2, "mid_wait", ok);
    if (ok) begin
      drive(2, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678);
      @(posedge clk);
      #1 idle_inputs(2);
      repeat (2) @(negedge clk);
      rst[2] = 1'b0;
      #1;
      chk("mid_wait rst_ready", 32'(req_ready[2]), 32'd0);
      chk("mid_wait rst_rdata", rsp_rdata[2], 32'd0);
      chk("mid_wait rst_err", 32'(rsp_err[2]), 32'd0);
      repeat (2) @(negedge clk);
      rst[2] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk("mid_wait no_rsp", 32'(rsp_valid[2]), 32'd0);
      end
    end
    do_txn(2, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1'b0, "mid_wait ld40");

    // Reset during RESP: the store is already committed.
    wait_ready(2, "mid_resp", ok);
    if (ok) begin
      drive(2, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678);
      @(posedge clk);
      #1 idle_inputs(2);
      repeat (5) @(negedge clk);
      chk("mid_resp pre_ready", 32'(req_ready[2]), 32'd0);
      chk("mid_resp pre_valid", 32'(rsp_valid[2]), 32'd0);
      rst[2] = 1'b0;
      repeat (2) @(negedge clk);
      rst[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("mid_resp no_rsp", 32'(rsp_valid[2]), 32'd0);
      end
    end
    do_txn(2, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0, "mid_resp ld40");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
